motor_drive_scheduler: RTL
==========================

# motor_drive_scheduler

Owns the H-bridge drive for the line-following robot and arbitrates it between two requesters: the autonomous navigation FSM and a manual/debug override. Enforces a dead-time (all bridge legs off) on every command change, ramps duty upward to limit inrush, and generates the per-leg PWM. Sits between the navigation FSM and the `uo_out` motor pins.

## Interface
- `DEAD_CYCLES`, 16: cycles with all legs off on any command change (1..255).
- `RAMP_DIV`, 64: clock cycles per duty ramp tick (1..65535).
- `RAMP_STEP`, 4: duty increment per ramp tick (1..255).
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `ena` in 1: block enable; low treated as no requests.
- `nav_req` in 1: navigation FSM requests the drive.
- `nav_cmd` in 2: 00 stop, 01 forward, 10 right, 11 left.
- `nav_duty` in 8: navigation target duty (0..255).
- `man_req` in 1: manual override requests the drive.
- `man_cmd` in 2: same encoding as `nav_cmd`.
- `man_duty` in 8: manual target duty.
- `grant` out 2: one-hot owner; bit0 nav, bit1 manual, 00 none.
- `motors` out 4: {A_d, A_i, B_d, B_i}.
- `active_cmd` out 2: command currently driven.
- `duty_now` out 8: current ramped duty.
- `dead` out 1: high while in DEAD.

## Operation
- Arbitration (combinational, registered into `grant`): `ena && man_req` → manual; else `ena && nav_req` → nav; else none. Fixed priority, manual preempts immediately.
- Target = winner's cmd/duty; no winner → cmd 00, duty 0. Target with duty 0 is treated as cmd 00.
- States: STOP, RAMP, RUN, DEAD.
- STOP: `duty_now`=0, `active_cmd`=00, legs off. Target cmd ≠ 00 → RAMP, `active_cmd` ← target cmd, ramp divider cleared.
- RAMP: every `RAMP_DIV` cycles `duty_now` += `RAMP_STEP`, saturating at target duty; reaching target → RUN. Target duty below `duty_now` → `duty_now` ← target immediately (no downward ramp), → RUN.
- RUN: `duty_now` follows target; target increase → RAMP.
- RAMP/RUN: target cmd ≠ `active_cmd` (incl. stop, incl. owner change with different cmd) → DEAD; dead counter ← `DEAD_CYCLES`, `duty_now` ← 0.
- DEAD: legs off; counter decrements each cycle; at 0 → STOP. Target changes during DEAD are ignored until STOP.
- Owner change with identical cmd: no DEAD; duty re-targets per RAMP/RUN rules.
- PWM: 8-bit free-running counter `pwm_cnt` from reset; `pwm` = `pwm_cnt < duty_now` (duty 255 → 255/256 high; duty 0 → always low).
- Leg mapping (RAMP/RUN only): forward A_d=B_d=pwm; right A_d=B_i=pwm; left A_i=B_d=pwm; all other legs 0. A_d&A_i and B_d&B_i never both 1.

## Timing
- All outputs registered; request/command change reflected in `grant`/state one cycle later, `motors` same cycle as state.
- Reset: state STOP, `grant`=00, `motors`=0000, `active_cmd`=00, `duty_now`=0, `dead`=0, `pwm_cnt`=0, all counters 0. Reset mid-DEAD or mid-RAMP aborts immediately, legs off asynchronously.
- Command change latency: 1 cycle to DEAD, `DEAD_CYCLES` cycles in DEAD, 1 cycle in STOP, then RAMP.
- Ramp 0→255 at defaults: 64 ticks × 64 cycles = 4096 cycles.

## Structure
- Package `motor_pkg`: cmd encodings (CMD_STOP/FWD/RIGHT/LEFT), state enum, leg-bit indices.
- Sub-module `motor_pwm_gen`: `pwm_cnt` counter and compare against `duty_now`; arbiter/FSM/ramp stay in top.

## Test plan
- Reset, nav_req=1 cmd 01 duty 128, defaults → grant 01, RAMP, `duty_now` reaches 128 after 32 ticks (2048 cycles), motors A_d=B_d toggling 128/256 duty.
- Steady forward, nav_cmd → 10 → DEAD 16 cycles with motors 0000, 1 cycle STOP, then RAMP with A_d=B_i from duty 0.
- Nav forward at 200, man_req=1 cmd 01 duty 50 → grant 10 next cycle, no DEAD, `duty_now` drops to 50 immediately.
- Nav forward, man_req=1 cmd 11 → grant 10, DEAD, then left; man_req drops → DEAD again, back to forward.
- ena=0 while RUN → grant 00, DEAD then STOP, motors 0000; rst_n low mid-RAMP → all outputs 0 without waiting for clock.
- Duty 255 in RUN → pwm low exactly 1 of 256 cycles; duty 0 request → stays STOP, motors never assert.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared encodings for the motor drive scheduler: commands, FSM states,
// H-bridge leg bit positions and the command-to-leg mapping.
package motor_pkg;

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_FWD   = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_LEFT  = 2'b11;

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DEAD = 2'd3;

    localparam int LEG_A_D = 3;
    localparam int LEG_A_I = 2;
    localparam int LEG_B_D = 1;
    localparam int LEG_B_I = 0;

    // Only one leg per side is ever driven, so shoot-through is impossible by construction.
    function automatic logic [3:0] leg_map(input logic [1:0] cmd, input logic pwm);
        logic [3:0] legs;
        legs = 4'b0000;
        case (cmd)
            CMD_FWD: begin
                legs[LEG_A_D] = pwm;
                legs[LEG_B_D] = pwm;
            end
            CMD_RIGHT: begin
                legs[LEG_A_D] = pwm;
                legs[LEG_B_I] = pwm;
            end
            CMD_LEFT: begin
                legs[LEG_A_I] = pwm;
                legs[LEG_B_D] = pwm;
            end
            default: legs = 4'b0000;
        endcase
        return legs;
    endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running 8-bit PWM counter; exposes the pwm level that will hold
// after the next edge so the caller can register it together with the FSM.
module motor_pwm_gen (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] duty_d_i,
    output logic       pwm_d_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign cnt_d   = cnt_q + 8'd1;
    assign pwm_d_o = (cnt_d < duty_d_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_drive_scheduler.sv
// H-bridge owner: arbitrates manual over navigation, inserts dead-time on
// command changes, ramps duty upward and drives the per-leg PWM.
module motor_drive_scheduler
    import motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 16,
    parameter int RAMP_DIV    = 64,
    parameter int RAMP_STEP   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    input  logic       nav_req_i,
    input  logic [1:0] nav_cmd_i,
    input  logic [7:0] nav_duty_i,
    input  logic       man_req_i,
    input  logic [1:0] man_cmd_i,
    input  logic [7:0] man_duty_i,
    output logic [1:0] grant_o,
    output logic [3:0] motors_o,
    output logic [1:0] active_cmd_o,
    output logic [7:0] duty_now_o,
    output logic       dead_o
);

    localparam logic [15:0] DIV_LAST  = 16'(RAMP_DIV - 1);
    localparam logic [7:0]  DEAD_INIT = 8'(DEAD_CYCLES);
    localparam logic [8:0]  STEP9     = 9'(RAMP_STEP);

    logic       man_win, nav_win;
    logic [1:0] tgt_cmd;
    logic [7:0] tgt_duty;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  duty_q, duty_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  dead_cnt_q, dead_cnt_d;
    logic [1:0]  grant_q;
    logic [3:0]  motors_q, motors_d;
    logic        dead_q;
    logic [8:0]  ramped;
    logic        pwm_d;

    // A zero-duty request is indistinguishable from a stop request.
    always_comb begin
        man_win  = ena_i & man_req_i;
        nav_win  = ena_i & nav_req_i & ~man_win;
        tgt_cmd  = CMD_STOP;
        tgt_duty = 8'd0;
        if (man_win) begin
            tgt_cmd  = man_cmd_i;
            tgt_duty = man_duty_i;
        end else if (nav_win) begin
            tgt_cmd  = nav_cmd_i;
            tgt_duty = nav_duty_i;
        end
        if (tgt_duty == 8'd0) begin
            tgt_cmd = CMD_STOP;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        duty_d     = duty_q;
        div_d      = div_q;
        dead_cnt_d = dead_cnt_q;
        ramped     = {1'b0, duty_q} + STEP9;
        case (state_q)
            ST_STOP: begin
                if (tgt_cmd != CMD_STOP) begin
                    state_d = ST_RAMP;
                    cmd_d   = tgt_cmd;
                    div_d   = 16'd0;
                end
            end
            ST_RAMP: begin
                if (tgt_cmd != cmd_q) begin
                    state_d    = ST_DEAD;
                    cmd_d      = CMD_STOP;
                    duty_d     = 8'd0;
                    div_d      = 16'd0;
                    dead_cnt_d = DEAD_INIT;
                end else if (tgt_duty <= duty_q) begin
                    duty_d  = tgt_duty;
                    state_d = ST_RUN;
                end else if (div_q == DIV_LAST) begin
                    div_d = 16'd0;
                    if (ramped >= {1'b0, tgt_duty}) begin
                        duty_d  = tgt_duty;
                        state_d = ST_RUN;
                    end else begin
                        duty_d = ramped[7:0];
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_RUN: begin
                if (tgt_cmd != cmd_q) begin
                    state_d    = ST_DEAD;
                    cmd_d      = CMD_STOP;
                    duty_d     = 8'd0;
                    div_d      = 16'd0;
                    dead_cnt_d = DEAD_INIT;
                end else if (tgt_duty > duty_q) begin
                    state_d = ST_RAMP;
                    div_d   = 16'd0;
                end else begin
                    duty_d = tgt_duty;
                end
            end
            ST_DEAD: begin
                dead_cnt_d = dead_cnt_q - 8'd1;
                if (dead_cnt_q <= 8'd1) begin
                    state_d    = ST_STOP;
                    dead_cnt_d = 8'd0;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    motor_pwm_gen u_pwm (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .duty_d_i (duty_d),
        .pwm_d_o  (pwm_d)
    );

    always_comb begin
        motors_d = 4'b0000;
        if ((state_d == ST_RAMP) || (state_d == ST_RUN)) begin
            motors_d = leg_map(cmd_d, pwm_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_STOP;
            cmd_q      <= CMD_STOP;
            duty_q     <= 8'd0;
            div_q      <= 16'd0;
            dead_cnt_q <= 8'd0;
            grant_q    <= 2'b00;
            motors_q   <= 4'b0000;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            duty_q     <= duty_d;
            div_q      <= div_d;
            dead_cnt_q <= dead_cnt_d;
            grant_q    <= {man_win, nav_win};
            motors_q   <= motors_d;
            dead_q     <= (state_d == ST_DEAD);
        end
    end

    assign grant_o      = grant_q;
    assign motors_o     = motors_q;
    assign active_cmd_o = cmd_q;
    assign duty_now_o   = duty_q;
    assign dead_o       = dead_q;

endmodule
